// File: rtl/mem_arbiter_if.sv
// Memory-side port of the shared-memory arbiter: one line-sized req/ack channel.
// master = arbiter (issues requests), slave = memory (acks and returns data).
interface mem_arbiter_if #(
  parameter int CACHE_LINE_WIDTH = 256,
  parameter int ADDR_WIDTH       = 16
);
  logic                        mem_req;
  logic                        mem_we;
  logic [ADDR_WIDTH-1:0]       mem_addr;
  logic [CACHE_LINE_WIDTH-1:0] mem_wdata;
  logic                        mem_ack;
  logic [CACHE_LINE_WIDTH-1:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_arbiter.sv
// Serialises I-cache and D-cache line misses onto one memory port.
// Ties alternate against the last served requester.
module mem_arbiter #(
  parameter int CACHE_LINE_WIDTH = 256,
  parameter int ADDR_WIDTH       = 16,
  parameter int OFFSET_BITS      = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_pet,
  input  logic [ADDR_WIDTH-1:0]       i_addr,
  output logic                        i_ready,
  output logic [CACHE_LINE_WIDTH-1:0] i_data,
  input  logic                        d_pet,
  input  logic                        d_we,
  input  logic [ADDR_WIDTH-1:0]       d_addr,
  input  logic [CACHE_LINE_WIDTH-1:0] d_wdata,
  output logic                        d_ready,
  output logic [CACHE_LINE_WIDTH-1:0] d_data,
  mem_arbiter_if.master               mem
);
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

  typedef struct packed {
    logic                        we;
    logic [ADDR_WIDTH-1:0]       addr;
    logic [CACHE_LINE_WIDTH-1:0] wdata;
  } mem_req_t;

  state_t   state, state_n;
  logic     last_d;
  logic     grant_i, grant_d, ack_i, ack_d;
  mem_req_t req_n;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    grant_i = 1'b0;
    grant_d = 1'b0;
    ack_i   = 1'b0;
    ack_d   = 1'b0;
    unique case (state)
      IDLE: begin
        // on a tie the side that was not served last wins
        if (i_pet && d_pet) begin
          grant_i = last_d;
          grant_d = !last_d;
        end else begin
          grant_i = i_pet;
          grant_d = d_pet;
        end
        if (grant_i)      state_n = SERVE_I;
        else if (grant_d) state_n = SERVE_D;
      end
      SERVE_I: if (mem.mem_ack) begin
        ack_i   = 1'b1;
        state_n = DONE;
      end
      SERVE_D: if (mem.mem_ack) begin
        ack_d   = 1'b1;
        state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // winner's request, line-aligned
  always_comb begin
    req_n.we    = grant_d & d_we;
    req_n.addr  = grant_d ? {d_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}}
                          : {i_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    req_n.wdata = grant_d ? d_wdata : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_d        <= 1'b0;
      i_ready       <= 1'b0;
      d_ready       <= 1'b0;
      i_data        <= '0;
      d_data        <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      i_ready <= ack_i;
      d_ready <= ack_d;
      if (grant_i || grant_d) begin
        mem.mem_req   <= 1'b1;
        mem.mem_we    <= req_n.we;
        mem.mem_addr  <= req_n.addr;
        mem.mem_wdata <= req_n.wdata;
      end
      if (ack_i || ack_d) begin
        mem.mem_req <= 1'b0;
        last_d      <= ack_d;
      end
      if (ack_i) i_data <= mem.mem_rdata;
      // write-backs leave the returned line untouched
      if (ack_d && !mem.mem_we) d_data <= mem.mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios, then randomized caches and memory,
// all checked every cycle against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int W  = 256;
  localparam int AW = 16;
  localparam int OB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_pet = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_ready;
  logic [W-1:0]  i_data;
  logic          d_pet = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [W-1:0]  d_wdata = '0;
  logic          d_ready;
  logic [W-1:0]  d_data;

  mem_arbiter_if #(.CACHE_LINE_WIDTH(W), .ADDR_WIDTH(AW)) mif();

  mem_arbiter #(.CACHE_LINE_WIDTH(W), .ADDR_WIDTH(AW), .OFFSET_BITS(OB)) dut (
    .clk(clk), .reset(reset),
    .i_pet(i_pet), .i_addr(i_addr), .i_ready(i_ready), .i_data(i_data),
    .d_pet(d_pet), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_data(d_data),
    .mem(mif)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int ir_cnt = 0;

  always @(negedge clk) if (i_ready === 1'b1) ir_cnt++;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
    logic [AW-1:0] m;
    m = '1;
    m = m << OB;
    return a & m;
  endfunction

  function automatic logic [W-1:0] rnd_line();
    logic [W-1:0] v;
    for (int k = 0; k < W/32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference: who owns the port (0 none, 1 I, 2 D), one-cycle turnaround flag,
  // and who was served last; outputs are what the caches/memory should see.
  int            m_own = 0;
  bit            m_cool = 1'b0;
  bit            m_last_d = 1'b0;
  logic          e_req = 1'b0, e_we = 1'b0, e_ir = 1'b0, e_dr = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [W-1:0]  e_wd = '0, e_id = '0, e_dd = '0;

  task automatic cycle();
    logic          s_rst, s_ip, s_dp, s_we, s_ack;
    logic [AW-1:0] s_ia, s_da;
    logic [W-1:0]  s_wd, s_rd;
    int            win;
    @(posedge clk);
    s_rst = reset; s_ip = i_pet; s_dp = d_pet; s_we = d_we; s_ack = mif.mem_ack;
    s_ia = i_addr; s_da = d_addr; s_wd = d_wdata; s_rd = mif.mem_rdata;
    e_ir = 1'b0;
    e_dr = 1'b0;
    if (!s_rst) begin
      m_own = 0; m_cool = 1'b0; m_last_d = 1'b0;
      e_req = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0; e_id = '0; e_dd = '0;
    end else if (m_own != 0) begin
      if (s_ack) begin
        e_req = 1'b0;
        m_cool = 1'b1;
        m_last_d = (m_own == 2);
        if (m_own == 1) begin
          e_ir = 1'b1; e_id = s_rd;
        end else begin
          e_dr = 1'b1;
          if (!e_we) e_dd = s_rd;
        end
        m_own = 0;
      end
    end else if (m_cool) begin
      m_cool = 1'b0;
    end else begin
      win = (s_ip && s_dp) ? (m_last_d ? 1 : 2) : (s_ip ? 1 : (s_dp ? 2 : 0));
      if (win == 1) begin
        m_own = 1; e_req = 1'b1; e_we = 1'b0; e_addr = align(s_ia); e_wd = '0;
      end else if (win == 2) begin
        m_own = 2; e_req = 1'b1; e_we = s_we; e_addr = align(s_da); e_wd = s_wd;
      end
    end
    #1;
    chk("mem_req",   W'(mif.mem_req),   W'(e_req));
    chk("mem_we",    W'(mif.mem_we),    W'(e_we));
    chk("mem_addr",  W'(mif.mem_addr),  W'(e_addr));
    chk("mem_wdata", mif.mem_wdata,     e_wd);
    chk("i_ready",   W'(i_ready),       W'(e_ir));
    chk("d_ready",   W'(d_ready),       W'(e_dr));
    chk("i_data",    i_data,            e_id);
    chk("d_data",    d_data,            e_dd);
  endtask

  initial begin
    int   aw, ir0;
    bit   i_drop, d_drop;
    logic [W-1:0] x1, x2, x3, x4, x5, x6;
    mif.mem_ack = 1'b0;
    mif.mem_rdata = '0;
    x1 = rnd_line(); x2 = rnd_line(); x3 = rnd_line();
    x4 = rnd_line(); x5 = rnd_line(); x6 = rnd_line();

    // reset state, then reset in the middle of an I service
    cycle(); cycle();
    chk("rst_req",   W'(mif.mem_req), W'(1'b0));
    chk("rst_idata", i_data, '0);
    reset = 1'b1; i_pet = 1'b1; i_addr = 16'h4321;
    cycle();
    chk("t1_req", W'(mif.mem_req), W'(1'b1));
    reset = 1'b0;
    cycle();
    chk("t1_req_drop", W'(mif.mem_req), W'(1'b0));
    mif.mem_ack = 1'b1; mif.mem_rdata = x1;
    cycle();
    chk("t1_no_ready", W'(i_ready), W'(1'b0));
    chk("t1_idata0", i_data, '0);
    reset = 1'b1; mif.mem_ack = 1'b0;
    cycle();
    chk("t1_regrant", W'(mif.mem_req), W'(1'b1));
    chk("t1_addr", W'(mif.mem_addr), W'(16'h4320));
    mif.mem_ack = 1'b1; mif.mem_rdata = x1;
    cycle();
    chk("t1_ready", W'(i_ready), W'(1'b1));
    mif.mem_ack = 1'b0; i_pet = 1'b0;
    cycle();

    // I read with a three-cycle memory
    reset = 1'b0; cycle(); cycle(); reset = 1'b1;
    i_pet = 1'b1; i_addr = 16'h1237;
    cycle();
    chk("t2_addr", W'(mif.mem_addr), W'(16'h1230));
    chk("t2_we", W'(mif.mem_we), W'(1'b0));
    cycle(); cycle();
    mif.mem_ack = 1'b1; mif.mem_rdata = {32{8'hA5}};
    cycle();
    chk("t2_ready", W'(i_ready), W'(1'b1));
    chk("t2_idata", i_data, {32{8'hA5}});
    chk("t2_dready", W'(d_ready), W'(1'b0));
    mif.mem_ack = 1'b0; i_pet = 1'b0;
    cycle();
    chk("t2_ready_end", W'(i_ready), W'(1'b0));

    // D write-back; inputs scrambled after grant must not leak through
    d_pet = 1'b1; d_we = 1'b1; d_addr = 16'h00FF; d_wdata = W'(1);
    cycle();
    chk("t3_we", W'(mif.mem_we), W'(1'b1));
    chk("t3_addr", W'(mif.mem_addr), W'(16'h00F0));
    chk("t3_wdata", mif.mem_wdata, W'(1));
    d_addr = 16'hFFFF; d_wdata = '1;
    cycle(); cycle();
    chk("t3_wdata_hold", mif.mem_wdata, W'(1));
    chk("t3_addr_hold", W'(mif.mem_addr), W'(16'h00F0));
    mif.mem_ack = 1'b1; mif.mem_rdata = x2;
    cycle();
    chk("t3_dready", W'(d_ready), W'(1'b1));
    chk("t3_ddata", d_data, '0);
    mif.mem_ack = 1'b0; d_pet = 1'b0; d_we = 1'b0;
    cycle();

    // simultaneous petitions after reset: D first, then I on the next tie
    reset = 1'b0; cycle(); reset = 1'b1;
    i_pet = 1'b1; i_addr = 16'h2345; d_pet = 1'b1; d_we = 1'b0; d_addr = 16'h6789;
    cycle();
    chk("t4_first_d", W'(mif.mem_addr), W'(16'h6780));
    mif.mem_ack = 1'b1; mif.mem_rdata = x1;
    cycle();
    chk("t4_dready", W'(d_ready), W'(1'b1));
    chk("t4_ddata", d_data, x1);
    mif.mem_ack = 1'b0; d_pet = 1'b0;
    cycle();
    chk("t4_gap", W'(mif.mem_req), W'(1'b0));
    d_pet = 1'b1; d_addr = 16'h0ABC;
    cycle();
    chk("t4_tie_i", W'(mif.mem_addr), W'(16'h2340));
    chk("t4_req_i", W'(mif.mem_req), W'(1'b1));
    mif.mem_ack = 1'b1; mif.mem_rdata = x2;
    cycle();
    chk("t4_iready", W'(i_ready), W'(1'b1));
    mif.mem_ack = 1'b0; i_pet = 1'b0;
    cycle(); cycle();
    chk("t4_then_d", W'(mif.mem_addr), W'(16'h0AB0));
    mif.mem_ack = 1'b1; mif.mem_rdata = x3;
    cycle();
    mif.mem_ack = 1'b0; d_pet = 1'b0;
    cycle();

    // stray acks in IDLE and in DONE
    mif.mem_ack = 1'b1; mif.mem_rdata = '1;
    cycle(); cycle();
    chk("t5_req", W'(mif.mem_req), W'(1'b0));
    chk("t5_iready", W'(i_ready), W'(1'b0));
    chk("t5_idata", i_data, x2);
    chk("t5_ddata", d_data, x3);
    mif.mem_ack = 1'b0; i_pet = 1'b1; i_addr = 16'h7770;
    cycle();
    mif.mem_ack = 1'b1; mif.mem_rdata = x4;
    cycle();
    mif.mem_rdata = '1; i_pet = 1'b0;
    cycle();
    chk("t5_done_ack", i_data, x4);
    chk("t5_done_req", W'(mif.mem_req), W'(1'b0));
    mif.mem_ack = 1'b0;
    cycle();

    // back-to-back I misses, petition held through DONE
    ir0 = ir_cnt;
    i_pet = 1'b1; i_addr = 16'h3456;
    cycle();
    chk("t6_addr1", W'(mif.mem_addr), W'(16'h3450));
    mif.mem_ack = 1'b1; mif.mem_rdata = x5;
    cycle();
    mif.mem_ack = 1'b0;
    cycle();
    chk("t6_no_regrant", W'(mif.mem_req), W'(1'b0));
    i_pet = 1'b0;
    cycle();
    i_pet = 1'b1; i_addr = 16'h9ABF;
    cycle();
    chk("t6_addr2", W'(mif.mem_addr), W'(16'h9AB0));
    mif.mem_ack = 1'b1; mif.mem_rdata = x6;
    cycle();
    mif.mem_ack = 1'b0; i_pet = 1'b0;
    cycle(); cycle();
    chk("t6_pulses", W'(ir_cnt - ir0), W'(2));
    chk("t6_idata", i_data, x6);

    // randomized caches and memory
    aw = -1; i_drop = 1'b0; d_drop = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 249) != 0);
      mif.mem_ack = 1'b0;
      if (!mif.mem_req) aw = -1;
      if (mif.mem_req) begin
        if (aw < 0) aw = $urandom_range(0, 3);
        if (aw == 0) begin
          mif.mem_ack = 1'b1; mif.mem_rdata = rnd_line(); aw = -1;
        end else aw--;
      end else if ($urandom_range(0, 7) == 0) begin
        mif.mem_ack = 1'b1; mif.mem_rdata = rnd_line();
      end

      if (i_drop) begin
        i_pet = 1'b0; i_drop = 1'b0;
      end else if (i_pet && i_ready) begin
        if ($urandom_range(0, 1) == 1) i_drop = 1'b1; else i_pet = 1'b0;
      end else if (i_pet && !mif.mem_req && $urandom_range(0, 15) == 0) begin
        i_pet = 1'b0;
      end else if (!i_pet && $urandom_range(0, 2) == 0) begin
        i_pet = 1'b1; i_addr = AW'($urandom);
      end

      if (d_drop) begin
        d_pet = 1'b0; d_drop = 1'b0;
      end else if (d_pet && d_ready) begin
        if ($urandom_range(0, 1) == 1) d_drop = 1'b1; else d_pet = 1'b0;
      end else if (d_pet && !mif.mem_req && $urandom_range(0, 15) == 0) begin
        d_pet = 1'b0;
      end else if (!d_pet && $urandom_range(0, 2) == 0) begin
        d_pet = 1'b1; d_we = 1'($urandom_range(0, 1));
        d_addr = AW'($urandom); d_wdata = rnd_line();
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
